xaui_tx_idle_gen: RTL
=====================

// Module: xaui_tx_idle_gen
// PURPOSE
//  XAUI PCS transmit encoder for one GTX quad (4 lanes, 2 bytes/lane/cycle) on xaui_clk.
//  Converts XGMII-style 64-bit data/8-bit control into mgt_txdata/mgt_txcharisk for xaui_infrastructure.
//  Replaces idle columns with the ||A||/||K||/||R|| sequence that the far-end receiver needs for:
//  comma alignment, channel sync (deskew) and loss-of-sync recovery.
//  Output feeds the TX side of one quad. The matching receiver is the comma-align/chansync path in the RX side.
// PARAMETERS
//  LFSR_SEED   7'h7F  reset value of the idle-randomisation LFSR; must be non-zero
//  A_MIN       16     minimum column spacing between ||A|| columns; spacing = A_MIN + lfsr[3:0]
// PORTS
//  xaui_clk        in   1   user clock, same clock as the GTX TXUSRCLK2
//  xaui_rst_n      in   1   asynchronous active-low reset
//  tx_en           in   1   0: force continuous ||K|| (link bring-up); 1: normal encoding
//  xgmii_txd       in   64  column0 = [31:0], column1 = [63:32]; lane L byte = [col*32+L*8 +: 8]
//  xgmii_txc       in   8   control flag per byte, same indexing as xgmii_txd (bit col*4+L)
//  mgt_txdata      out  64  lane L = [L*16 +: 16]; column0 byte in [L*16 +: 8], column1 byte in [L*16+8 +: 8]
//  mgt_txcharisk   out  8   K flag per byte, bit L*2+col
//  a_sent_count    out  16  free-running count of ||A|| columns sent; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - mgt_txdata = {8{8'hBC}}, mgt_txcharisk = 8'hFF, a_sent_count = 0
//    - lfsr = LFSR_SEED, a_cnt = A_MIN
//  - Latency: one registered stage; input in cycle n appears at outputs in cycle n+1.
//  - Column processing order: column0 first, then column1. Column1 uses lfsr/a_cnt as updated by column0.
//  - LFSR: 7-bit, polynomial x^7+x^6+1, shift-left, new bit = lfsr[6]^lfsr[5]. Steps exactly once per column (twice per cycle).
//  - Idle column: all 4 bytes have txc=1 and data 8'h07.
//    - a_cnt==0: emit ||A|| (8'h7C, K=1 on all lanes), reload a_cnt = A_MIN + lfsr[3:0], increment a_sent_count.
//    - else if lfsr[0]==1: emit ||R|| (8'h1C, K=1 on all lanes).
//    - else: emit ||K|| (8'hBC, K=1 on all lanes).
//    - In both non-A cases, a_cnt decrements by 1.
//  - Non-idle column, per byte:
//    - txc=0: data passes through, K=0.
//    - txc=1 with 8'hFB/8'hFD/8'h9C/8'hFE: passes through, K=1.
//    - txc=1 with 8'h07: encoded as 8'hBC, K=1.
//    - txc=1 with any other value: 8'hFE, K=1.
//    - a_cnt decrements if non-zero; at 0 it holds, and ||A|| goes out on the next idle column.
//  - tx_en=0: every column is ||K||. LFSR still steps, a_cnt holds, no ||A|| is sent.
//    On the first cycle after tx_en rises, normal encoding resumes with the held a_cnt.
//  - Two ||A|| columns are never closer than A_MIN columns apart. With continuous idle, spacing is A_MIN..A_MIN+15 columns inclusive.
//  - Reset asserted mid-stream: outputs go to reset values immediately (async). No partial-column state survives.
//  - Control-byte sequencing (for example, a start byte outside lane 0) is not checked. The MAC upstream owns framing.
// TESTING
//  1 Reset release, continuous idle (txd=64'h0707..07, txc=8'hFF):
//    - first ||A|| appears at column 16 after release.
//    - every idle column is all-7C, all-1C or all-BC with charisk=8'hFF.
//    - every gap between ||A|| columns is in 16..31.
//  2 tx_en=0 for 100 cycles:
//    - txdata = {8{8'hBC}}, charisk = 8'hFF, a_sent_count unchanged.
//    - raise tx_en: the first ||A|| arrives after the held a_cnt columns.
//  3 Frame input:
//    - cycle n, col0 = FB,55,55,55 (txc 0001); data columns after it (txc=0).
//    - cycle n+1: lane0 byte = FB with K=1; data bytes unchanged with K=0.
//  4 Terminate column FD,07,07,07 (txc 1111):
//    - output FD,BC,BC,BC with K=1111.
//    - the next all-idle column is A, K or R; it is A only if a_cnt==0.
//  5 Invalid control byte 8'h3C with txc=1 -> output 8'hFE, K=1.
//    - Sequence byte 9C in lane0 with data in lanes 1-3 -> 9C passes through with K=1.
//  6 Assert xaui_rst_n=0 mid-frame -> outputs at reset values in the same cycle.
//    - After release, the LFSR sequence repeats exactly from LFSR_SEED (compare against a golden model).

Source files
------------

// File: rtl/xaui_tx_idle_gen.sv
// XAUI PCS transmit encoder for one GTX quad: XGMII columns to 8b/10b-ready bytes,
// with idle columns replaced by the randomised ||A||/||K||/||R|| sequence.
module xaui_tx_idle_gen #(
    parameter logic [6:0] LFSR_SEED = 7'h7F,
    parameter int         A_MIN     = 16
) (
    input  logic        xaui_clk,
    input  logic        xaui_rst_n,
    input  logic        tx_en,
    input  logic [63:0] xgmii_txd,
    input  logic [7:0]  xgmii_txc,
    output logic [63:0] mgt_txdata,
    output logic [7:0]  mgt_txcharisk,
    output logic [15:0] a_sent_count
);

    localparam int AW = $clog2(A_MIN + 16);

    typedef struct packed {
        logic [31:0]   data;
        logic [3:0]    k;
        logic [6:0]    lfsr;
        logic [AW-1:0] a_cnt;
        logic          a_sent;
    } col_t;

    logic [6:0]    lfsr;
    logic [AW-1:0] a_cnt;
    col_t          c0;
    col_t          c1;
    logic [63:0]   nxt_data;
    logic [7:0]    nxt_k;

    // Encodes one 4-lane column; decisions use the LFSR value before it steps.
    function automatic col_t enc_col(
        input logic [31:0]   d,
        input logic [3:0]    c,
        input logic          en,
        input logic [6:0]    lf,
        input logic [AW-1:0] ac
    );
        col_t       r;
        logic       idle;
        logic [7:0] b;
        r.data   = {4{8'hBC}};
        r.k      = 4'hF;
        r.lfsr   = {lf[5:0], lf[6] ^ lf[5]};
        r.a_cnt  = ac;
        r.a_sent = 1'b0;
        idle     = (c == 4'hF) && (d == {4{8'h07}});
        if (en && idle) begin
            if (ac == '0) begin
                r.data   = {4{8'h7C}};
                r.a_cnt  = AW'(A_MIN) + AW'(lf[3:0]);
                r.a_sent = 1'b1;
            end else begin
                if (lf[0])
                    r.data = {4{8'h1C}};
                r.a_cnt = ac - 1'b1;
            end
        end else if (en) begin
            for (int l = 0; l < 4; l++) begin
                b = d[l*8 +: 8];
                if (!c[l]) begin
                    r.data[l*8 +: 8] = b;
                    r.k[l]           = 1'b0;
                end else begin
                    unique case (b)
                        8'hFB, 8'hFD, 8'h9C, 8'hFE: r.data[l*8 +: 8] = b;
                        8'h07:                      r.data[l*8 +: 8] = 8'hBC;
                        default:                    r.data[l*8 +: 8] = 8'hFE;
                    endcase
                end
            end
            if (ac != '0)
                r.a_cnt = ac - 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        c0       = enc_col(xgmii_txd[31:0], xgmii_txc[3:0], tx_en, lfsr, a_cnt);
        c1       = enc_col(xgmii_txd[63:32], xgmii_txc[7:4], tx_en, c0.lfsr, c0.a_cnt);
        nxt_data = '0;
        nxt_k    = '0;
        // Lane-major output: each lane carries column0 in its low byte.
        for (int l = 0; l < 4; l++) begin
            nxt_data[l*16 +: 8]     = c0.data[l*8 +: 8];
            nxt_data[l*16 + 8 +: 8] = c1.data[l*8 +: 8];
            nxt_k[l*2]              = c0.k[l];
            nxt_k[l*2 + 1]          = c1.k[l];
        end
    end

    always_ff @(posedge xaui_clk or negedge xaui_rst_n) begin
        if (!xaui_rst_n) begin
            mgt_txdata    <= {8{8'hBC}};
            mgt_txcharisk <= 8'hFF;
            a_sent_count  <= '0;
            lfsr          <= LFSR_SEED;
            a_cnt         <= AW'(A_MIN);
        end else begin
            mgt_txdata    <= nxt_data;
            mgt_txcharisk <= nxt_k;
            a_sent_count  <= a_sent_count + 16'(c0.a_sent) + 16'(c1.a_sent);
            lfsr          <= c1.lfsr;
            a_cnt         <= c1.a_cnt;
        end
    end

endmodule
